// File: rtl/serial_mult_ctrl.sv
// ---------------------------------------------------------------------------
// serial_mult_ctrl
//   Sequential shift-add unsigned multiplier. A single 1-bit full-adder cell
//   is time-shared bit-serially: each multiplier iteration spends WIDTH
//   cycles in ADD, one per bit of the accumulator. It then spends one cycle
//   in SHIFT, which moves {cy,P,Q} right by one. Latency is fixed and does
//   not depend on the operand values.
//
// Ports
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset
//   start   in   1        request, sampled only while ready=1
//   mcand   in   WIDTH    multiplicand, captured with an accepted start
//   mplier  in   WIDTH    multiplier, captured with an accepted start
//   ready   out  1        high in IDLE only
//   busy    out  1        high in ADD and SHIFT
//   done    out  1        one-cycle pulse; prod is valid in that cycle
//   prod    out  2*WIDTH  registered product, held until the next done
//
// Handshake: when start=1 in a cycle where ready=1, the operation is accepted
// on that clock edge. Exactly one done pulse follows, WIDTH*(WIDTH+1)+1
// cycles later. A start seen while ready=0 is ignored completely.
// ---------------------------------------------------------------------------
module serial_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] p_reg;
    logic             cy;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    iter_cnt;

    // Full-adder cell operands. The multiplier LSB gates the addend bit, so a
    // zero multiplier bit still walks through all WIDTH ADD cycles.
    logic fa_a;
    logic fa_b;
    logic fa_c;
    logic fa_sum;
    logic fa_carry;

    always_comb begin
        fa_a     = p_reg[0];
        fa_b     = a_reg[0] & q_reg[0];
        fa_c     = cy;
        fa_sum   = fa_a ^ fa_b ^ fa_c;
        fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
    end

    // Next values of P and Q for the SHIFT step: {cy,P,Q} >> 1.
    logic [WIDTH-1:0] p_shift;
    logic [WIDTH-1:0] q_shift;

    always_comb begin
        p_shift = {cy, p_reg[WIDTH-1:1]};
        q_shift = {p_reg[0], q_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            q_reg    <= '0;
            p_reg    <= '0;
            cy       <= 1'b0;
            bit_cnt  <= '0;
            iter_cnt <= '0;
            prod     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg    <= mcand;
                        q_reg    <= mplier;
                        p_reg    <= '0;
                        cy       <= 1'b0;
                        bit_cnt  <= '0;
                        iter_cnt <= '0;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    // P and A both rotate right one bit per cycle. After
                    // WIDTH cycles they are back in alignment, and P holds
                    // the low WIDTH bits of P + addend, with the carry-out
                    // left in cy.
                    p_reg <= {fa_sum, p_reg[WIDTH-1:1]};
                    a_reg <= {a_reg[0], a_reg[WIDTH-1:1]};
                    cy    <= fa_carry;
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    p_reg <= p_shift;
                    q_reg <= q_shift;
                    cy    <= 1'b0;
                    if (iter_cnt == LAST) begin
                        prod  <= {p_shift, q_shift};
                        state <= S_DONE;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                        state    <= S_ADD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state == S_ADD) || (state == S_SHIFT);
        done  = (state == S_DONE);
    end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Testbench for serial_mult_ctrl. It runs two instances, one with WIDTH=4 and
// one with WIDTH=8.
//
// The reference model works from the timing rule for the block:
//   - An operation is accepted in cycle k.
//   - The block is busy in cycles k+1 .. k+L, where L = W*(W+1).
//   - done is high in cycle k+L+1.
//   - ready is high at all other times.
// The expected product is a*b.
module tb_serial_mult_ctrl;

    localparam int L4 = 4 * 5;
    localparam int L8 = 8 * 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [3:0]  mcand4 = '0;
    logic [3:0]  mplier4 = '0;
    logic        ready4, busy4, done4;
    logic [7:0]  prod4;

    logic        start8 = 1'b0;
    logic [7:0]  mcand8 = '0;
    logic [7:0]  mplier8 = '0;
    logic        ready8, busy8, done8;
    logic [15:0] prod8;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Scoreboard: expected products and acceptance cycles.
    logic [7:0]  exp_q4[$];
    logic [15:0] exp_q8[$];
    int          win4[$];
    int          win8[$];
    logic [7:0]  last4 = '0;
    logic [15:0] last8 = '0;

    serial_mult_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mcand(mcand4), .mplier(mplier4),
        .ready(ready4), .busy(busy4), .done(done4), .prod(prod4)
    );

    serial_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mcand(mcand8), .mplier(mplier8),
        .ready(ready8), .busy(busy8), .done(done8), .prod(prod8)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // {ready,busy,done} expected in cycle c for an op accepted in cycle k.
    function automatic logic [2:0] model_status(input bit active, input int k, input int c, input int lat);
        if (!active || c <= k) return 3'b100;
        if (c <= k + lat) return 3'b010;
        return 3'b001;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (win4.size() > 0 && cyc > win4[0] + L4 + 1) void'(win4.pop_front());
            check("status4", 32'({ready4, busy4, done4}),
                  32'(model_status(win4.size() > 0, (win4.size() > 0) ? win4[0] : 0, cyc, L4)));
            if (done4 === 1'b1) begin
                if (exp_q4.size() == 0) begin
                    n_checks++;
                    $display("FAIL done4_unexpected: got done with prod %0d, expected no done (cycle %0d)", prod4, cyc);
                end else begin
                    last4 = exp_q4.pop_front();
                    check("prod4", 32'(prod4), 32'(last4));
                end
            end else begin
                check("prod_hold4", 32'(prod4), 32'(last4));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (win8.size() > 0 && cyc > win8[0] + L8 + 1) void'(win8.pop_front());
            check("status8", 32'({ready8, busy8, done8}),
                  32'(model_status(win8.size() > 0, (win8.size() > 0) ? win8[0] : 0, cyc, L8)));
            if (done8 === 1'b1) begin
                if (exp_q8.size() == 0) begin
                    n_checks++;
                    $display("FAIL done8_unexpected: got done with prod %0d, expected no done (cycle %0d)", prod8, cyc);
                end else begin
                    last8 = exp_q8.pop_front();
                    check("prod8", 32'(prod8), 32'(last8));
                end
            end else begin
                check("prod_hold8", 32'(prod8), 32'(last8));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit wide);
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            if ((wide ? ready8 : ready4) === 1'b1) return;
        end
        n_checks++;
        $display("FAIL ready_timeout: got ready=0 for 300 cycles, expected ready=1 (cycle %0d)", cyc);
    endtask

    task automatic issue(input bit wide, input int a, input int b, output int k);
        wait_ready(wide);
        k = cyc;
        if (wide) begin
            start8 = 1'b1; mcand8 = 8'(a); mplier8 = 8'(b);
            exp_q8.push_back(16'(a * b)); win8.push_back(k);
        end else begin
            start4 = 1'b1; mcand4 = 4'(a); mplier4 = 4'(b);
            exp_q4.push_back(8'(a * b)); win4.push_back(k);
        end
        next_cycle();
        // Operands change after acceptance; the result must not follow them.
        if (wide) begin
            start8 = 1'b0; mcand8 = 8'($urandom); mplier8 = 8'($urandom);
        end else begin
            start4 = 1'b0; mcand4 = 4'($urandom); mplier4 = 4'($urandom);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        #1;
        check("rst_status4", 32'({ready4, busy4, done4}), 32'(3'b100));
        check("rst_prod4", 32'(prod4), 32'd0);
        check("rst_status8", 32'({ready8, busy8, done8}), 32'(3'b100));
        check("rst_prod8", 32'(prod8), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Basic products and data-independent latency.
        issue(1'b0, 3, 5, k);
        issue(1'b0, 15, 15, k);
        issue(1'b0, 0, 9, k);
        issue(1'b0, 15, 0, k);

        // A start pulse during an operation is ignored.
        issue(1'b0, 6, 7, k);
        wait_until(k + 5);
        start4 = 1'b1; mcand4 = 4'd1; mplier4 = 4'd1;
        next_cycle();
        start4 = 1'b0;

        // start held high: back-to-back operations.
        wait_ready(1'b0);
        k = cyc;
        start4 = 1'b1; mcand4 = 4'd2; mplier4 = 4'd3;
        exp_q4.push_back(8'd6); win4.push_back(k);
        next_cycle();
        mcand4 = 4'd4; mplier4 = 4'd4;
        exp_q4.push_back(8'd16); win4.push_back(k + L4 + 2);
        wait_until(k + L4 + 2);
        check("b2b_ready", 32'(ready4), 32'd1);
        next_cycle();
        start4 = 1'b0;

        // Asynchronous reset in the middle of an operation.
        issue(1'b0, 9, 9, k);
        wait_until(k + 10);
        #2;
        rst_n = 1'b0;
        exp_q4.delete(); win4.delete(); last4 = '0; last8 = '0;
        #1;
        check("async_rst_status4", 32'({ready4, busy4, done4}), 32'(3'b100));
        check("async_rst_prod4", 32'(prod4), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        issue(1'b0, 9, 9, k);

        // Random WIDTH=4 traffic, with occasional ignored start pulses.
        for (int i = 0; i < 40; i++) begin
            issue(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), k);
            if ($urandom_range(0, 3) == 0) begin
                wait_until(k + int'($urandom_range(2, 15)));
                start4 = 1'b1; mcand4 = 4'($urandom); mplier4 = 4'($urandom);
                next_cycle();
                start4 = 1'b0;
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) next_cycle();
        end

        // WIDTH=8 instance.
        issue(1'b1, 255, 255, k);
        issue(1'b1, 0, 255, k);
        for (int i = 0; i < 200; i++) begin
            issue(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), k);
        end

        wait_ready(1'b1);
        wait_ready(1'b0);
        next_cycle();
        next_cycle();
        check("drain4", 32'(exp_q4.size()), 32'd0);
        check("drain8", 32'(exp_q8.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
